// File: rtl/ram_burst_master.sv
// Burst initiator for the single-port synchronous RAM: one command at a time,
// write beats from a valid/ready stream, read beats back on a valid-only stream.
module ram_burst_master #(
  parameter int addr_size = 10,
  parameter int data_size = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_rw,
  input  logic [addr_size-1:0] cmd_addr,
  input  logic [addr_size-1:0] cmd_len,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [data_size-1:0] wr_data,
  output logic                 rd_valid,
  output logic [data_size-1:0] rd_data,
  output logic                 busy,
  output logic                 done,
  output logic                 ram_cs,
  output logic                 ram_rw,
  output logic [addr_size-1:0] ram_addr,
  output logic [data_size-1:0] ram_din,
  input  logic [data_size-1:0] ram_dout
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  localparam logic [addr_size-1:0] ONE = addr_size'(1);

  state_t               r_state, w_next;
  logic [addr_size-1:0] r_cur, r_rem;
  logic                 r_ram_cs, r_ram_rw;
  logic [addr_size-1:0] r_ram_addr;
  logic [data_size-1:0] r_ram_din, r_rd_data;
  // [0]: read on the RAM pins, [1]: data on ram_dout, [2]: data on rd_data
  logic [2:0]           r_vld_pipe;
  logic                 w_wr_hs, w_rd_issue;

  assign cmd_ready  = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign done       = (r_state == DONE);
  assign wr_ready   = (r_state == WRITE) && (r_rem != '0);
  assign w_wr_hs    = wr_valid && wr_ready;
  assign w_rd_issue = (r_state == READ) && (r_rem != '0);

  assign rd_valid = r_vld_pipe[2];
  assign rd_data  = r_rd_data;
  assign ram_cs   = r_ram_cs;
  assign ram_rw   = r_ram_rw;
  assign ram_addr = r_ram_addr;
  assign ram_din  = r_ram_din;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_len == '0) w_next = DONE;
          else if (cmd_rw)   w_next = WRITE;
          else               w_next = READ;
        end
      end
      WRITE:   if (w_wr_hs && r_rem == ONE)    w_next = DRAIN;
      READ:    if (w_rd_issue && r_rem == ONE) w_next = DRAIN;
      // reads still in flight keep us here; writes finish after one cycle
      DRAIN:   if (r_vld_pipe[1:0] == 2'b00)   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur      <= '0;
      r_rem      <= '0;
      r_ram_cs   <= 1'b0;
      r_ram_rw   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
      r_rd_data  <= '0;
      r_vld_pipe <= '0;
    end else begin
      r_ram_cs   <= 1'b0;
      r_vld_pipe <= {r_vld_pipe[1:0], w_rd_issue};
      if (r_state == IDLE && cmd_valid) begin
        r_cur <= cmd_addr;
        r_rem <= cmd_len;
      end
      if (w_wr_hs) begin
        r_ram_cs   <= 1'b1;
        r_ram_rw   <= 1'b1;
        r_ram_addr <= r_cur;
        r_ram_din  <= wr_data;
        r_cur      <= r_cur + ONE;
        r_rem      <= r_rem - ONE;
      end
      if (w_rd_issue) begin
        r_ram_cs   <= 1'b1;
        r_ram_rw   <= 1'b0;
        r_ram_addr <= r_cur;
        r_cur      <= r_cur + ONE;
        r_rem      <= r_rem - ONE;
      end
      if (r_vld_pipe[1]) r_rd_data <= ram_dout;
    end
  end

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed bench for ram_burst_master with a behavioural single-port RAM behind it;
// all expected cycles are relative to the cycle the command is presented.
module tb_ram_burst_master;
  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cmd_valid = 1'b0, cmd_rw = 1'b0;
  logic [AW-1:0] cmd_addr = '0, cmd_len = '0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          cmd_ready, wr_ready, rd_valid, busy, done;
  logic [DW-1:0] rd_data, ram_din;
  logic          ram_cs, ram_rw;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout = '0;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  ram_burst_master #(.addr_size(AW), .data_size(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .done(done),
    .ram_cs(ram_cs), .ram_rw(ram_rw), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // single-port synchronous RAM: write lands at the edge, read data follows it
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_rw) mem[ram_addr] <= ram_din;
      else        ram_dout      <= mem[ram_addr];
    end
  end

  int            wr_cyc[$], ri_cyc[$], rv_cyc[$], dn_cyc[$];
  logic [AW-1:0] wr_addr[$], ri_addr[$];
  logic [DW-1:0] wr_dat[$], rv_dat[$];

  always @(negedge clk) begin
    if (ram_cs === 1'b1 && ram_rw === 1'b1) begin
      wr_cyc.push_back(cyc); wr_addr.push_back(ram_addr); wr_dat.push_back(ram_din);
    end
    if (ram_cs === 1'b1 && ram_rw === 1'b0) begin
      ri_cyc.push_back(cyc); ri_addr.push_back(ram_addr);
    end
    if (rd_valid === 1'b1) begin
      rv_cyc.push_back(cyc); rv_dat.push_back(rd_data);
    end
    if (done === 1'b1) dn_cyc.push_back(cyc);
  end

  task automatic clear_logs();
    wr_cyc.delete(); wr_addr.delete(); wr_dat.delete();
    ri_cyc.delete(); ri_addr.delete();
    rv_cyc.delete(); rv_dat.delete(); dn_cyc.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic rw, input logic [AW-1:0] a, input logic [AW-1:0] l,
                        output int c0);
    tick();
    c0 = cyc;
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_len = l;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic run_write(input logic [AW-1:0] a, input logic [AW-1:0] l, input logic [7:0] vm,
                           input logic [7:0][DW-1:0] d, input int nb, output int c0);
    clear_logs();
    do_cmd(1'b1, a, l, c0);
    for (int i = 0; i < nb; i++) begin
      wr_valid = vm[i]; wr_data = d[i];
      tick();
    end
    wr_valid = 1'b0;
    while (cyc < c0 + nb + 6) tick();
  endtask

  task automatic run_read(input logic [AW-1:0] a, input int l, output int r0);
    clear_logs();
    do_cmd(1'b0, a, AW'(l), r0);
    while (cyc < r0 + l + 8) tick();
  endtask

  task automatic test_reset();
    #12;
    n_chk++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if ({done, wr_ready, rd_valid, ram_cs} !== 4'b0)
      $display("FAIL reset_strobes: got done/wr_ready/rd_valid/ram_cs=%b want 0000", {done, wr_ready, rd_valid, ram_cs});
    else n_pass++;
    n_chk++; if ({ram_rw, ram_addr, ram_din, rd_data} !== '0)
      $display("FAIL reset_data: got rw=%b addr=%h din=%h rd_data=%h want all 0", ram_rw, ram_addr, ram_din, rd_data);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    int c0, r0;
    int ec[2]; logic [AW-1:0] ea[2]; logic [DW-1:0] ed[2];
    run_write(10'h001, 10'd2, 8'b0000_0011, {48'h0, 8'd12, 8'd14}, 2, c0);
    ec = '{c0 + 2, c0 + 3}; ea = '{10'h001, 10'h002}; ed = '{8'd14, 8'd12};
    n_chk++; if (wr_cyc.size() != 2) $display("FAIL wr_count: got %0d want 2", wr_cyc.size()); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (i >= wr_cyc.size()) $display("FAIL wr_beat%0d: missing, want addr %h data %0d", i, ea[i], ed[i]);
      else if (wr_cyc[i] !== ec[i] || wr_addr[i] !== ea[i] || wr_dat[i] !== ed[i])
        $display("FAIL wr_beat%0d: got +%0d addr %h data %0d want +%0d addr %h data %0d",
                 i, wr_cyc[i] - c0, wr_addr[i], wr_dat[i], ec[i] - c0, ea[i], ed[i]);
      else n_pass++;
    end
    n_chk++; if (dn_cyc.size() != 1 || dn_cyc[0] != c0 + 4)
      $display("FAIL wr_done: got %0d pulses first +%0d want 1 pulse at +4", dn_cyc.size(), dn_cyc.size() ? dn_cyc[0] - c0 : -1);
    else n_pass++;

    run_read(10'h001, 2, r0);
    ec = '{r0 + 2, r0 + 3};
    n_chk++; if (ri_cyc.size() != 2) $display("FAIL rd_issue_count: got %0d want 2", ri_cyc.size()); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (i >= ri_cyc.size()) $display("FAIL rd_issue%0d: missing", i);
      else if (ri_cyc[i] !== ec[i] || ri_addr[i] !== ea[i])
        $display("FAIL rd_issue%0d: got +%0d addr %h want +%0d addr %h", i, ri_cyc[i] - r0, ri_addr[i], ec[i] - r0, ea[i]);
      else n_pass++;
    end
    ec = '{r0 + 4, r0 + 5};
    n_chk++; if (rv_cyc.size() != 2) $display("FAIL rd_beat_count: got %0d want 2", rv_cyc.size()); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (i >= rv_cyc.size()) $display("FAIL rd_beat%0d: missing, want data %0d", i, ed[i]);
      else if (rv_cyc[i] !== ec[i] || rv_dat[i] !== ed[i])
        $display("FAIL rd_beat%0d: got +%0d data %0d want +%0d data %0d", i, rv_cyc[i] - r0, rv_dat[i], ec[i] - r0, ed[i]);
      else n_pass++;
    end
    n_chk++; if (dn_cyc.size() != 1 || dn_cyc[0] != r0 + 6)
      $display("FAIL rd_done: got %0d pulses first +%0d want 1 pulse at +6", dn_cyc.size(), dn_cyc.size() ? dn_cyc[0] - r0 : -1);
    else n_pass++;
    n_chk++; if (cmd_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL idle_after_read: got cmd_ready=%b busy=%b want 1/0", cmd_ready, busy);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int c0, r0;
    logic [AW-1:0] ea[4]; logic [DW-1:0] ed[4];
    ea = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    ed = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    run_write(10'h3FE, 10'd4, 8'h0F, {32'h0, 8'hA3, 8'hA2, 8'hA1, 8'hA0}, 4, c0);
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (i >= wr_cyc.size()) $display("FAIL wrap_wr%0d: missing", i);
      else if (wr_cyc[i] !== c0 + 2 + i || wr_addr[i] !== ea[i] || wr_dat[i] !== ed[i])
        $display("FAIL wrap_wr%0d: got +%0d addr %h data %h want +%0d addr %h data %h",
                 i, wr_cyc[i] - c0, wr_addr[i], wr_dat[i], 2 + i, ea[i], ed[i]);
      else n_pass++;
    end
    n_chk++; if (dn_cyc.size() != 1 || dn_cyc[0] != c0 + 6)
      $display("FAIL wrap_wr_done: got %0d pulses first +%0d want 1 at +6", dn_cyc.size(), dn_cyc.size() ? dn_cyc[0] - c0 : -1);
    else n_pass++;

    run_read(10'h3FE, 4, r0);
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (i >= rv_cyc.size()) $display("FAIL wrap_rd%0d: missing, want data %h", i, ed[i]);
      else if (rv_cyc[i] !== r0 + 4 + i || rv_dat[i] !== ed[i])
        $display("FAIL wrap_rd%0d: got +%0d data %h want +%0d data %h", i, rv_cyc[i] - r0, rv_dat[i], 4 + i, ed[i]);
      else n_pass++;
    end
    n_chk++; if (ri_cyc.size() != 4 || ri_addr[2] !== 10'h000)
      $display("FAIL wrap_rd_addr: got %0d issues, third addr %h want 4 issues, third 000",
               ri_cyc.size(), ri_cyc.size() > 2 ? ri_addr[2] : 10'h3FF);
    else n_pass++;
    n_chk++; if (dn_cyc.size() != 1 || dn_cyc[0] != r0 + 8)
      $display("FAIL wrap_rd_done: got %0d pulses first +%0d want 1 at +8", dn_cyc.size(), dn_cyc.size() ? dn_cyc[0] - r0 : -1);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int c0;
    logic [DW-1:0] ed[3];
    ed = '{8'h31, 8'h32, 8'h33};
    run_write(10'h010, 10'd3, 8'b0001_0101, {24'h0, 8'h33, 8'h00, 8'h32, 8'h00, 8'h31}, 5, c0);
    n_chk++; if (wr_cyc.size() != 3) $display("FAIL bp_wr_count: got %0d want 3", wr_cyc.size()); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (i >= wr_cyc.size()) $display("FAIL bp_wr%0d: missing", i);
      else if (wr_cyc[i] !== c0 + 2 + 2 * i || wr_addr[i] !== AW'(16 + i) || wr_dat[i] !== ed[i])
        $display("FAIL bp_wr%0d: got +%0d addr %h data %h want +%0d addr %h data %h",
                 i, wr_cyc[i] - c0, wr_addr[i], wr_dat[i], 2 + 2 * i, 16 + i, ed[i]);
      else n_pass++;
    end
    n_chk++; if (dn_cyc.size() != 1 || dn_cyc[0] != c0 + 7)
      $display("FAIL bp_done: got %0d pulses first +%0d want 1 at +7", dn_cyc.size(), dn_cyc.size() ? dn_cyc[0] - c0 : -1);
    else n_pass++;
  endtask

  task automatic test_zero_len();
    int c0;
    clear_logs();
    tick();
    c0 = cyc;
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 10'h007; cmd_len = '0;
    tick();
    n_chk++; if (busy !== 1'b1 || cmd_ready !== 1'b0)
      $display("FAIL zl_busy: got busy=%b cmd_ready=%b want 1/0", busy, cmd_ready);
    else n_pass++;
    tick();
    cmd_valid = 1'b0;
    n_chk++; if (cmd_ready !== 1'b1) $display("FAIL zl_cmd_ready: got %b want 1", cmd_ready); else n_pass++;
    while (cyc < c0 + 8) tick();
    n_chk++; if (dn_cyc.size() != 1 || dn_cyc[0] != c0 + 1)
      $display("FAIL zl_done: got %0d pulses first +%0d want 1 at +1", dn_cyc.size(), dn_cyc.size() ? dn_cyc[0] - c0 : -1);
    else n_pass++;
    n_chk++; if (wr_cyc.size() + ri_cyc.size() != 0)
      $display("FAIL zl_no_access: got %0d RAM accesses want 0", wr_cyc.size() + ri_cyc.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    int r0, rc, c0;
    clear_logs();
    do_cmd(1'b0, 10'h000, 10'd8, r0);
    while (cyc < r0 + 4) tick();
    n_chk++; if (ram_cs !== 1'b1) $display("FAIL mr_issuing: got ram_cs=%b want 1 before reset", ram_cs); else n_pass++;
    rst_n = 1'b0;
    #1;
    rc = cyc;
    n_chk++; if (ram_cs !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL mr_async: got ram_cs=%b busy=%b cmd_ready=%b want 0/0/1", ram_cs, busy, cmd_ready);
    else n_pass++;
    tick(); tick();
    rst_n = 1'b1;
    while (cyc < rc + 8) tick();
    n_chk++; if (ri_cyc.size() != 2) $display("FAIL mr_issues: got %0d logged issues want 2", ri_cyc.size()); else n_pass++;
    n_chk++; if (rv_cyc.size() != 0 || dn_cyc.size() != 0)
      $display("FAIL mr_silent: got %0d rd_valid %0d done want 0/0", rv_cyc.size(), dn_cyc.size());
    else n_pass++;
    n_chk++; if (cmd_ready !== 1'b1) $display("FAIL mr_ready: got %b want 1", cmd_ready); else n_pass++;

    run_write(10'h005, 10'd1, 8'h01, {56'h0, 8'h5A}, 1, c0);
    n_chk++; if (wr_cyc.size() != 1 || wr_cyc[0] != c0 + 2 || wr_addr[0] !== 10'h005 || dn_cyc.size() != 1 || dn_cyc[0] != c0 + 3)
      $display("FAIL mr_post_write: got %0d writes %0d dones want 1 write at +2 to 005, done at +3", wr_cyc.size(), dn_cyc.size());
    else n_pass++;
    run_read(10'h005, 1, r0);
    n_chk++; if (rv_cyc.size() != 1 || rv_cyc[0] != r0 + 4 || rv_dat[0] !== 8'h5A)
      $display("FAIL mr_post_read: got %0d beats first +%0d data %h want 1 at +4 data 5a",
               rv_cyc.size(), rv_cyc.size() ? rv_cyc[0] - r0 : -1, rv_cyc.size() ? rv_dat[0] : 8'h00);
    else n_pass++;
    n_chk++; if (dn_cyc.size() != 1 || dn_cyc[0] != r0 + 5)
      $display("FAIL mr_post_done: got %0d pulses first +%0d want 1 at +5", dn_cyc.size(), dn_cyc.size() ? dn_cyc[0] - r0 : -1);
    else n_pass++;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    test_reset();
    test_write_read();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule
